router_fifo: RTL and testbench

//   Per-destination output buffer of the 1x3 router: three instances sit directly downstream of router_sync.

---
 rtl/router_fifo_pkg.sv | 29 ++
 rtl/router_fifo_if.sv | 31 +++
 rtl/router_fifo.sv | 97 +++++++++
 tb/tb_router_fifo.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/router_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : router_fifo_pkg
// Description : Shared router constants and header-byte field helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package router_fifo_pkg;

   localparam int DATA_WIDTH      = 8;
   localparam int FIFO_DEPTH      = 16;
   localparam int FIFO_ADDR_WIDTH = 4;
   localparam int PKT_CNT_WIDTH   = 6;

   // Header byte layout: payload length in the upper six bits, destination in the lower two.
   typedef struct packed {
      logic [PKT_CNT_WIDTH-1:0] len;
      logic [1:0]               dest;
   } hdr_t;

   function automatic logic [PKT_CNT_WIDTH-1:0] hdr_len(input hdr_t h);
      return h.len;
   endfunction

   function automatic logic [1:0] hdr_dest(input hdr_t h);
      return h.dest;
   endfunction

endpackage
`default_nettype wire

// File: rtl/router_fifo_if.sv
`default_nettype none
// ============================================================================
// Module      : router_fifo_if
// Description : Write/read strobes, data and status between router_sync, the
//               destination port and one output FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
interface router_fifo_if;
   import router_fifo_pkg::*;

   logic                  soft_reset;
   logic                  write_enb;
   logic                  read_enb;
   logic                  lfd_state;
   logic [DATA_WIDTH-1:0] data_in;
   logic                  full;
   logic                  empty;
   logic [DATA_WIDTH-1:0] data_out;

   modport master (
      output soft_reset, write_enb, read_enb, lfd_state, data_in,
      input  full, empty, data_out
   );

   modport slave (
      input  soft_reset, write_enb, read_enb, lfd_state, data_in,
      output full, empty, data_out
   );

endinterface
`default_nettype wire

// File: rtl/router_fifo.sv
`default_nettype none
// ============================================================================
// Module      : router_fifo
// Description : Per-destination output buffer storing header-tagged bytes
//               with registered read data and packet-length tracking.
// Revision    : 1.0 - initial release
// ============================================================================
module router_fifo
   import router_fifo_pkg::*;
#(
   parameter int DEPTH      = FIFO_DEPTH,
   parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
   input  wire             clock,
   input  wire             resetn,
   router_fifo_if.slave    bus
);

   localparam logic [ADDR_WIDTH:0]    PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
   localparam logic [PKT_CNT_WIDTH-1:0] CNT_ONE = {{(PKT_CNT_WIDTH-1){1'b0}}, 1'b1};

   logic [DATA_WIDTH:0]        mem_q [DEPTH];
   logic [ADDR_WIDTH:0]        wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH:0]        rd_ptr_q, rd_ptr_d;
   logic [PKT_CNT_WIDTH-1:0]   pkt_cnt_q, pkt_cnt_d;
   logic [DATA_WIDTH-1:0]      data_out_q, data_out_d;

   logic                       w_full;
   logic                       w_empty;
   logic                       w_wr_accept;
   logic                       w_rd_accept;
   logic [DATA_WIDTH:0]        w_rd_word;

   // Extra wrap bit distinguishes full from empty when the low bits match.
   assign w_empty     = (wr_ptr_q == rd_ptr_q);
   assign w_full      = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) &&
                        (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);
   assign w_wr_accept = bus.write_enb && !w_full;
   assign w_rd_accept = bus.read_enb  && !w_empty;
   assign w_rd_word   = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];

   assign bus.full     = w_full;
   assign bus.empty    = w_empty;
   assign bus.data_out = data_out_q;

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      pkt_cnt_d  = pkt_cnt_q;
      data_out_d = data_out_q;
      if (w_wr_accept) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (w_rd_accept) begin
         rd_ptr_d   = rd_ptr_q + PTR_ONE;
         data_out_d = w_rd_word[DATA_WIDTH-1:0];
         // A header reloads the count with payload length plus the parity byte.
         if (w_rd_word[DATA_WIDTH]) begin
            pkt_cnt_d = hdr_len(hdr_t'(w_rd_word[DATA_WIDTH-1:0])) + CNT_ONE;
         end else if (pkt_cnt_q != '0) begin
            pkt_cnt_d = pkt_cnt_q - CNT_ONE;
         end
      end else if (pkt_cnt_q == '0) begin
         data_out_d = '0;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         pkt_cnt_q  <= '0;
         data_out_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (bus.soft_reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         pkt_cnt_q  <= '0;
         data_out_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         pkt_cnt_q  <= pkt_cnt_d;
         data_out_q <= data_out_d;
         if (w_wr_accept) begin
            mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= {bus.lfd_state, bus.data_in};
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_router_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_router_fifo
// Description : Directed self-checking bench for router_fifo.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_router_fifo;
   import router_fifo_pkg::*;

   logic clk;
   logic rst_n;
   int   n_checks = 0;
   int   n_pass   = 0;

   router_fifo_if bus();

   router_fifo dut (
      .clock  (clk),
      .resetn (rst_n),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_byte(input logic lfd, input logic [7:0] d);
      bus.write_enb = 1'b1;
      bus.lfd_state = lfd;
      bus.data_in   = d;
      tick();
      bus.write_enb = 1'b0;
      bus.lfd_state = 1'b0;
   endtask

   task automatic test_reset();
      n_checks++; if (bus.empty !== 1'b1) $display("FAIL rst_empty: got %b expected 1", bus.empty); else n_pass++;
      n_checks++; if (bus.full !== 1'b0) $display("FAIL rst_full: got %b expected 0", bus.full); else n_pass++;
      n_checks++; if (bus.data_out !== 8'h00) $display("FAIL rst_dout: got %h expected 00", bus.data_out); else n_pass++;
      rst_n = 1'b1;
      tick();
      write_byte(1'b0, 8'h3C);
      write_byte(1'b0, 8'h5D);
      bus.read_enb = 1'b1;
      tick();
      bus.read_enb = 1'b0;
      n_checks++; if (bus.data_out !== 8'h3C) $display("FAIL pre_rst_dout: got %h expected 3c", bus.data_out); else n_pass++;
      #2 rst_n = 1'b0;
      #1;
      n_checks++; if (bus.empty !== 1'b1) $display("FAIL async_empty: got %b expected 1", bus.empty); else n_pass++;
      n_checks++; if (bus.full !== 1'b0) $display("FAIL async_full: got %b expected 0", bus.full); else n_pass++;
      n_checks++; if (bus.data_out !== 8'h00) $display("FAIL async_dout: got %h expected 00", bus.data_out); else n_pass++;
      #2 rst_n = 1'b1;
      tick();
   endtask

   task automatic test_packet();
      logic [7:0] exp_d [5] = '{8'h0E, 8'hA1, 8'hB2, 8'hC3, 8'hDE};
      logic [5:0] exp_c [5] = '{6'd4, 6'd3, 6'd2, 6'd1, 6'd0};
      write_byte(1'b1, 8'h0E);
      write_byte(1'b0, 8'hA1);
      write_byte(1'b0, 8'hB2);
      write_byte(1'b0, 8'hC3);
      write_byte(1'b0, 8'hDE);
      bus.read_enb = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_checks++; if (bus.data_out !== exp_d[i]) $display("FAIL pkt_dout[%0d]: got %h expected %h", i, bus.data_out, exp_d[i]); else n_pass++;
         n_checks++; if (dut.pkt_cnt_q !== exp_c[i]) $display("FAIL pkt_cnt[%0d]: got %0d expected %0d", i, dut.pkt_cnt_q, exp_c[i]); else n_pass++;
      end
      bus.read_enb = 1'b0;
      tick();
      n_checks++; if (bus.data_out !== 8'h00) $display("FAIL pkt_idle_dout: got %h expected 00", bus.data_out); else n_pass++;
      n_checks++; if (bus.empty !== 1'b1) $display("FAIL pkt_empty: got %b expected 1", bus.empty); else n_pass++;
   endtask

   task automatic test_full();
      for (int i = 1; i <= 16; i++) begin
         write_byte(1'b0, 8'(i));
         if (i == 15) begin
            n_checks++; if (bus.full !== 1'b0) $display("FAIL full_at15: got %b expected 0", bus.full); else n_pass++;
         end
      end
      n_checks++; if (bus.full !== 1'b1) $display("FAIL full_at16: got %b expected 1", bus.full); else n_pass++;
      write_byte(1'b0, 8'h99);
      n_checks++; if (bus.full !== 1'b1) $display("FAIL full_after_drop: got %b expected 1", bus.full); else n_pass++;
      bus.read_enb = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         tick();
         n_checks++; if (bus.data_out !== 8'(i)) $display("FAIL full_rd[%0d]: got %h expected %h", i, bus.data_out, 8'(i)); else n_pass++;
      end
      bus.read_enb = 1'b0;
      n_checks++; if (bus.empty !== 1'b1) $display("FAIL full_drained: got %b expected 1", bus.empty); else n_pass++;
      tick();
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 16; i++) write_byte(1'b0, 8'(8'h40 + i));
      bus.read_enb  = 1'b1;
      bus.write_enb = 1'b1;
      bus.data_in   = 8'hEE;
      tick();
      n_checks++; if (bus.data_out !== 8'h40) $display("FAIL rw_full_dout: got %h expected 40", bus.data_out); else n_pass++;
      n_checks++; if (bus.full !== 1'b0) $display("FAIL rw_full_flag: got %b expected 0", bus.full); else n_pass++;
      bus.data_in = 8'h77;
      tick();
      bus.write_enb = 1'b0;
      n_checks++; if (bus.data_out !== 8'h41) $display("FAIL rw_mid_dout: got %h expected 41", bus.data_out); else n_pass++;
      n_checks++; if (bus.full !== 1'b0 || bus.empty !== 1'b0) $display("FAIL rw_mid_flags: got full=%b empty=%b expected 0 0", bus.full, bus.empty); else n_pass++;
      for (int i = 0; i < 15; i++) begin
         logic [7:0] e;
         e = (i < 14) ? 8'(8'h42 + i) : 8'h77;
         tick();
         n_checks++; if (bus.data_out !== e) $display("FAIL rw_drain[%0d]: got %h expected %h", i, bus.data_out, e); else n_pass++;
      end
      bus.read_enb = 1'b0;
      n_checks++; if (bus.empty !== 1'b1) $display("FAIL rw_drained: got %b expected 1", bus.empty); else n_pass++;
      tick();
   endtask

   task automatic test_soft_reset();
      logic [7:0] exp_d [3] = '{8'h05, 8'h5A, 8'h5F};
      logic [5:0] exp_c [3] = '{6'd2, 6'd1, 6'd0};
      write_byte(1'b1, 8'h0E);
      write_byte(1'b0, 8'hA1);
      write_byte(1'b0, 8'hB2);
      bus.read_enb = 1'b1;
      tick();
      bus.read_enb = 1'b0;
      n_checks++; if (dut.pkt_cnt_q !== 6'd4) $display("FAIL srst_pre_cnt: got %0d expected 4", dut.pkt_cnt_q); else n_pass++;
      bus.soft_reset = 1'b1;
      bus.write_enb  = 1'b1;
      bus.data_in    = 8'hCC;
      tick();
      bus.soft_reset = 1'b0;
      bus.write_enb  = 1'b0;
      n_checks++; if (bus.empty !== 1'b1) $display("FAIL srst_empty: got %b expected 1", bus.empty); else n_pass++;
      n_checks++; if (bus.data_out !== 8'h00) $display("FAIL srst_dout: got %h expected 00", bus.data_out); else n_pass++;
      n_checks++; if (dut.pkt_cnt_q !== 6'd0) $display("FAIL srst_cnt: got %0d expected 0", dut.pkt_cnt_q); else n_pass++;
      write_byte(1'b1, 8'h05);
      write_byte(1'b0, 8'h5A);
      write_byte(1'b0, 8'h5F);
      bus.read_enb = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++; if (bus.data_out !== exp_d[i]) $display("FAIL srst_pkt_dout[%0d]: got %h expected %h", i, bus.data_out, exp_d[i]); else n_pass++;
         n_checks++; if (dut.pkt_cnt_q !== exp_c[i]) $display("FAIL srst_pkt_cnt[%0d]: got %0d expected %0d", i, dut.pkt_cnt_q, exp_c[i]); else n_pass++;
      end
      bus.read_enb = 1'b0;
      n_checks++; if (bus.empty !== 1'b1) $display("FAIL srst_pkt_empty: got %b expected 1", bus.empty); else n_pass++;
      tick();
   endtask

   task automatic test_wrap();
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < 10; i++) write_byte(1'b0, 8'(8'h80 + r * 16 + i));
         n_checks++; if (bus.full !== 1'b0 || bus.empty !== 1'b0) $display("FAIL wrap_flags[%0d]: got full=%b empty=%b expected 0 0", r, bus.full, bus.empty); else n_pass++;
         bus.read_enb = 1'b1;
         for (int i = 0; i < 10; i++) begin
            tick();
            n_checks++; if (bus.data_out !== 8'(8'h80 + r * 16 + i)) $display("FAIL wrap_rd[%0d][%0d]: got %h expected %h", r, i, bus.data_out, 8'(8'h80 + r * 16 + i)); else n_pass++;
         end
         bus.read_enb = 1'b0;
         n_checks++; if (bus.empty !== 1'b1) $display("FAIL wrap_empty[%0d]: got %b expected 1", r, bus.empty); else n_pass++;
      end
      for (int i = 0; i < 16; i++) write_byte(1'b0, 8'(8'hC0 + i));
      n_checks++; if (bus.full !== 1'b1) $display("FAIL wrap_full: got %b expected 1", bus.full); else n_pass++;
      bus.read_enb = 1'b1;
      for (int i = 0; i < 16; i++) begin
         tick();
         n_checks++; if (bus.data_out !== 8'(8'hC0 + i)) $display("FAIL wrap_full_rd[%0d]: got %h expected %h", i, bus.data_out, 8'(8'hC0 + i)); else n_pass++;
      end
      bus.read_enb = 1'b0;
      n_checks++; if (bus.empty !== 1'b1) $display("FAIL wrap_final_empty: got %b expected 1", bus.empty); else n_pass++;
      tick();
   endtask

   initial begin
      rst_n          = 1'b0;
      bus.soft_reset = 1'b0;
      bus.write_enb  = 1'b0;
      bus.read_enb   = 1'b0;
      bus.lfd_state  = 1'b0;
      bus.data_in    = 8'h00;
      #2;
      test_reset();
      test_packet();
      test_full();
      test_back_to_back();
      test_soft_reset();
      test_wrap();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
